// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall/bubble/flush enables, EX operand
// forwarding selects, multi-cycle EX freeze and the debug halt drain/hold handshake.
module pipeline_hazard_ctrl #(
    parameter int unsigned MC_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       ex_memtoreg,
    input  logic       ex_branch_taken,
    input  logic       ex_jump,
    input  logic       ex_mc_start,
    input  logic       mem_regwr,
    input  logic [4:0] mem_rw,
    input  logic       wr_regwr,
    input  logic [4:0] wr_rw,
    input  logic       halt_req,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       idex_we,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       exmem_bubble,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       halt_ack,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMcWait = 2'd1,
        StDrain  = 2'd2,
        StHalted = 2'd3
    } state_e;

    localparam logic [3:0] McInit = 4'(MC_CYCLES - 2);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       halt_ack_q, halt_ack_d;

    logic       pc_we_c, ifid_we_c, idex_we_c, ifid_flush_c, idex_bubble_c, exmem_bubble_c;
    logic [1:0] fwd_a_c, fwd_b_c;
    logic       redirect, load_use;

    assign redirect = ex_branch_taken | ex_jump;
    assign load_use = ex_memtoreg & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_comb begin
        fwd_a_c = 2'b00;
        if (mem_regwr && (mem_rw == ex_rs)) begin
            fwd_a_c = 2'b01;
        end else if (wr_regwr && (wr_rw == ex_rs)) begin
            fwd_a_c = 2'b10;
        end
        fwd_b_c = 2'b00;
        if (mem_regwr && (mem_rw == ex_rt)) begin
            fwd_b_c = 2'b01;
        end else if (wr_regwr && (wr_rw == ex_rt)) begin
            fwd_b_c = 2'b10;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_we_c        = 1'b1;
        ifid_we_c      = 1'b1;
        idex_we_c      = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        exmem_bubble_c = 1'b0;
        unique case (state_q)
            StRun: begin
                if (redirect) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    // A redirect with a multi-cycle op still lets the PC and IF/ID take the target.
                    if (ex_mc_start) begin
                        idex_we_c      = 1'b0;
                        exmem_bubble_c = 1'b1;
                        state_d        = StMcWait;
                        cnt_d          = McInit;
                    end
                end else if (ex_mc_start) begin
                    pc_we_c        = 1'b0;
                    ifid_we_c      = 1'b0;
                    idex_we_c      = 1'b0;
                    exmem_bubble_c = 1'b1;
                    state_d        = StMcWait;
                    cnt_d          = McInit;
                end else if (load_use) begin
                    pc_we_c       = 1'b0;
                    ifid_we_c     = 1'b0;
                    idex_bubble_c = 1'b1;
                end else if (halt_req) begin
                    state_d = StDrain;
                    cnt_d   = 4'd2;
                end
            end
            StMcWait: begin
                pc_we_c        = 1'b0;
                ifid_we_c      = 1'b0;
                idex_we_c      = 1'b0;
                exmem_bubble_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDrain: begin
                pc_we_c       = redirect;
                ifid_we_c     = 1'b0;
                ifid_flush_c  = redirect;
                idex_bubble_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StHalted;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHalted: begin
                pc_we_c        = 1'b0;
                ifid_we_c      = 1'b0;
                idex_we_c      = 1'b0;
                idex_bubble_c  = 1'b1;
                exmem_bubble_c = 1'b1;
                if (!halt_req) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        halt_ack_d = (state_d == StHalted);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StRun;
            cnt_q      <= 4'd0;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    // Reset forces the combinational controls too, not only the registers.
    always_comb begin
        pc_we        = RESET & pc_we_c;
        ifid_we      = RESET & ifid_we_c;
        idex_we      = RESET & idex_we_c;
        ifid_flush   = RESET & ifid_flush_c;
        idex_bubble  = ~RESET | idex_bubble_c;
        exmem_bubble = ~RESET | exmem_bubble_c;
        fwd_a        = RESET ? fwd_a_c : 2'b00;
        fwd_b        = RESET ? fwd_b_c : 2'b00;
        halt_ack     = halt_ack_q;
        state        = state_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MC_CYCLES = 4).
module tb_pipeline_hazard_ctrl;

    logic       CLK, RESET;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_rw, wr_rw;
    logic       id_uses_rt, ex_memtoreg, ex_branch_taken, ex_jump, ex_mc_start;
    logic       mem_regwr, wr_regwr, halt_req;
    logic       pc_we, ifid_we, idex_we, ifid_flush, idex_bubble, exmem_bubble, halt_ack;
    logic [1:0] fwd_a, fwd_b, state;

    int checks = 0;
    int failures = 0;
    int frozen;
    logic done;

    pipeline_hazard_ctrl #(.MC_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memtoreg(ex_memtoreg),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .ex_mc_start(ex_mc_start),
        .mem_regwr(mem_regwr), .mem_rw(mem_rw), .wr_regwr(wr_regwr), .wr_rw(wr_rw),
        .halt_req(halt_req),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halt_ack(halt_ack), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_memtoreg = 1'b0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0; ex_mc_start = 1'b0;
        mem_regwr = 1'b0; mem_rw = 5'd0; wr_regwr = 1'b0; wr_rw = 5'd0;
        halt_req = 1'b0;
    endtask

    initial begin
        clr();
        RESET = 1'b0;
        // Would forward 01 if reset did not force fwd to 00.
        mem_regwr = 1'b1; mem_rw = 5'd4; ex_rs = 5'd4;
        #12;
        chk1("rst_pc_we", pc_we, 1'b0);
        chk1("rst_idex_we", idex_we, 1'b0);
        chk1("rst_idex_bubble", idex_bubble, 1'b1);
        chk1("rst_exmem_bubble", exmem_bubble, 1'b1);
        chk2("rst_fwd_a", fwd_a, 2'b00);
        chk2("rst_state", state, 2'd0);
        chk1("rst_halt_ack", halt_ack, 1'b0);

        tick();
        RESET = 1'b1;
        clr();
        #1;
        chk1("idle_pc_we", pc_we, 1'b1);
        chk1("idle_idex_bubble", idex_bubble, 1'b0);

        // Forwarding priority
        mem_regwr = 1'b1; mem_rw = 5'd3; wr_regwr = 1'b1; wr_rw = 5'd3;
        ex_rs = 5'd3; ex_rt = 5'd7;
        #1;
        chk2("fwd_a_exmem", fwd_a, 2'b01);
        chk2("fwd_b_none", fwd_b, 2'b00);
        mem_regwr = 1'b0;
        #1;
        chk2("fwd_a_memwr", fwd_a, 2'b10);
        ex_rt = 5'd3;
        #1;
        chk2("fwd_b_memwr", fwd_b, 2'b10);

        // Load-use on rs
        tick();
        clr();
        ex_memtoreg = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        chk1("lu_pc_we", pc_we, 1'b0);
        chk1("lu_ifid_we", ifid_we, 1'b0);
        chk1("lu_idex_bubble", idex_bubble, 1'b1);
        chk2("lu_state", state, 2'd0);
        tick();
        clr();
        mem_regwr = 1'b0; // bubble now in EX
        #1;
        chk1("lu_next_pc_we", pc_we, 1'b1);
        tick();
        clr();
        ex_rs = 5'd5; wr_regwr = 1'b1; wr_rw = 5'd5;
        #1;
        chk2("lu_consumer_fwd_a", fwd_a, 2'b10);

        // Load-use on rt depends on id_uses_rt
        tick();
        clr();
        ex_memtoreg = 1'b1; ex_rt = 5'd6; id_rs = 5'd1; id_rt = 5'd6;
        #1;
        chk1("lu_rt_unused", pc_we, 1'b1);
        id_uses_rt = 1'b1;
        #1;
        chk1("lu_rt_used", pc_we, 1'b0);

        // Load-use + taken branch: redirect wins
        ex_branch_taken = 1'b1;
        #1;
        chk1("lu_br_pc_we", pc_we, 1'b1);
        chk1("lu_br_flush", ifid_flush, 1'b1);
        chk1("lu_br_idex_bubble", idex_bubble, 1'b1);

        // Multi-cycle op: frozen cycles N..N+3, RUN at N+4
        tick();
        clr();
        ex_mc_start = 1'b1;
        #1;
        chk1("mc_n_idex_we", idex_we, 1'b0);
        chk1("mc_n_exmem_bubble", exmem_bubble, 1'b1);
        chk2("mc_n_state", state, 2'd0);
        tick();
        clr();
        #1;
        chk2("mc_n1_state", state, 2'd1);
        chk1("mc_n1_idex_we", idex_we, 1'b0);
        tick();
        ex_branch_taken = 1'b1;
        #1;
        chk1("mc_n2_br_flush", ifid_flush, 1'b0);
        chk1("mc_n2_br_pc_we", pc_we, 1'b0);
        chk2("mc_n2_state", state, 2'd1);
        tick();
        clr();
        #1;
        chk2("mc_n3_state", state, 2'd1);
        chk1("mc_n3_idex_we", idex_we, 1'b0);
        tick();
        chk2("mc_n4_state", state, 2'd0);
        chk1("mc_n4_idex_we", idex_we, 1'b1);

        // Halt: RUN at H, DRAIN H+1..H+3, HALTED at H+4
        halt_req = 1'b1;
        #1;
        chk1("halt_h_pc_we", pc_we, 1'b1);
        tick();
        chk2("halt_h1_state", state, 2'd2);
        chk1("halt_h1_pc_we", pc_we, 1'b0);
        chk1("halt_h1_idex_we", idex_we, 1'b1);
        chk1("halt_h1_idex_bubble", idex_bubble, 1'b1);
        tick();
        ex_jump = 1'b1;
        #1;
        chk2("halt_h2_state", state, 2'd2);
        chk1("drain_jump_pc_we", pc_we, 1'b1);
        chk1("drain_jump_flush", ifid_flush, 1'b1);
        tick();
        ex_jump = 1'b0;
        #1;
        chk2("halt_h3_state", state, 2'd2);
        chk1("halt_h3_ack", halt_ack, 1'b0);
        tick();
        chk2("halt_h4_state", state, 2'd3);
        chk1("halt_h4_ack", halt_ack, 1'b1);
        chk1("halt_h4_pc_we", pc_we, 1'b0);
        chk1("halt_h4_idex_we", idex_we, 1'b0);
        chk1("halt_h4_exmem_bubble", exmem_bubble, 1'b1);
        tick();
        tick();
        chk1("halted_hold_ack", halt_ack, 1'b1);
        halt_req = 1'b0;
        #1;
        chk1("halt_drop_m_ack", halt_ack, 1'b1);
        tick();
        chk2("halt_drop_m1_state", state, 2'd0);
        chk1("halt_drop_m1_ack", halt_ack, 1'b0);

        // DRAIN completes even if halt_req drops
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        tick();
        chk2("drain_drop_h3_state", state, 2'd2);
        tick();
        chk2("drain_drop_h4_state", state, 2'd3);
        chk1("drain_drop_h4_ack", halt_ack, 1'b1);
        tick();
        chk2("drain_drop_h5_state", state, 2'd0);

        // Reset during MCWAIT with cnt=2
        ex_mc_start = 1'b1;
        tick();
        ex_mc_start = 1'b0;
        #1;
        chk2("mcrst_pre_state", state, 2'd1);
        RESET = 1'b0;
        #1;
        chk2("mcrst_state", state, 2'd0);
        chk1("mcrst_idex_bubble", idex_bubble, 1'b1);
        chk1("mcrst_pc_we", pc_we, 1'b0);
        tick();
        RESET = 1'b1;
        #1;
        chk1("mcrst_release_pc_we", pc_we, 1'b1);
        tick();
        ex_mc_start = 1'b1;
        #1;
        frozen = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (idex_we) begin
                done = 1'b1;
            end else begin
                frozen++;
                tick();
                ex_mc_start = 1'b0;
                #1;
            end
        end
        chk1("mcrst_restart_done", done, 1'b1);
        chki("mcrst_restart_frozen", frozen, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
